mpmc11_rd_resp_collect_fta: RTL and testbench
=============================================

Name: mpmc11_rd_resp_collect_fta

Overview:
- Read-response stage directly downstream of the mpmc11 controller state machine.
- Counts DDR read beats and drives the resp_burst_cnt that the state machine compares against burst_len.
- Tags each 256-bit beat with the request's tid and beat address, and buffers beats in a small FIFO for the channel response path.
- Flags overflow, stray beats and timed-out (short) bursts.

Parameters:
- DEPTH, 16, response FIFO entries (power of two, 4..64)
- AWID, 32, address width
- DWID, 256, beat data width (32 bytes per beat)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- state  in  mpmc11_state_t  current controller state
- fifo_out  in  fta_cmd_request256_t  command being serviced; tid, adr and cmd are used
- burst_len  in  6  last beat index of the burst (beats = burst_len+1)
- rd_data_valid  in  1  DDR read beat strobe
- rd_data  in  DWID  DDR read beat data
- resp_burst_cnt  out  6  index of the next expected beat
- resp_v  out  1  FIFO head valid
- resp_rdy  in  1  consumer accepts head
- resp_beat  out  mpmc11_rd_beat_t  head entry {tid, adr, dat, last}
- resp_cnt  out  $clog2(DEPTH)+1  FIFO occupancy
- ovf  out  1  sticky: a beat was dropped because the FIFO was full
- stray  out  1  one-cycle pulse: rd_data_valid arrived outside a read phase
- short_burst  out  1  one-cycle pulse: read phase ended before the last beat

Behaviour:
- Reset values: resp_burst_cnt=0, FIFO empty, resp_v=0, resp_cnt=0, ovf=0, stray=0, short_burst=0. Reset mid-burst discards all buffered and partial beats.
- Read phase: state is READ_DATA0, READ_DATA1 or READ_DATA2. The collect flag is registered internally.
- Capture at phase entry: on the first cycle state is READ_DATA0, latch fifo_out.tid and fifo_out.adr with the low 5 address bits cleared, plus burst_len.
- Beat acceptance: rd_data_valid during the read phase is a beat. Beat address = base + resp_burst_cnt*32 (mod 2^AWID). last = (resp_burst_cnt == latched burst_len).
- Counter: on each beat, resp_burst_cnt increments unless last. It holds at burst_len after the last beat so the state machine sees cnt==burst_len together with rd_data_valid. It clears to 0 on any cycle state==IDLE.
- Push: each beat is pushed in the same cycle it arrives. It becomes visible on resp_v the next cycle (1-cycle latency).
- Pop: occurs when resp_v && resp_rdy. resp_beat is the registered FIFO head.
- Full FIFO: a beat arriving while full with no simultaneous pop is dropped and ovf sets; ovf clears only on rst. Full with a simultaneous pop: the push is accepted and occupancy is unchanged.
- Empty FIFO: resp_v=0 and resp_rdy is ignored. Simultaneous push and pop on empty is impossible because of the 1-cycle latency; the push lands.
- Extra beats: a beat arriving after last within the same phase is treated as stray. It is not pushed and the counter is unchanged.
- Stray beats: rd_data_valid outside the read phase gives stray=1 for that cycle and the beat is discarded.
- Short burst: if the state leaves the read phase for IDLE (controller timeout) with fewer than burst_len+1 beats accepted, short_burst pulses for one cycle. Beats already pushed remain; no synthetic last beat is generated.
- ALU commands (CMD_ADD..CMD_CAS): beats are collected identically. The consumer filters by tid.
- Pointers wrap modulo DEPTH. Occupancy is tracked with an extra MSB.

Decomposition:
- mpmc11_pkg gains mpmc11_rd_beat_t {tid, adr[AWID], dat[DWID], last} and the constant MPMC11_BEAT_BYTES=32.
- Sub-module mpmc11_sync_fifo (parameterised width/depth, registered head, push/pop/full/empty/count) holds the buffer.
- Counter, phase tracking and error pulses stay in the top module.

Test Plan:
- Single beat: burst_len=0, adr=0x1234_5678, tid=5, one rd_data_valid in READ_DATA2 -> one entry {tid=5, adr=0x1234_5660, last=1}; resp_v rises the next cycle; resp_burst_cnt stays 0 until IDLE.
- Burst of 4: burst_len=3, base 0x1000, beats on consecutive cycles with resp_rdy=0 -> entries at 0x1000/0x1020/0x1040/0x1060, last only on the 4th; resp_burst_cnt 0,1,2,3,3; resp_cnt=4.
- Overflow: DEPTH=4 already full, resp_rdy=0, one beat -> beat dropped, ovf=1 and sticky; same case with resp_rdy=1 -> beat accepted, resp_cnt stays 4, ovf=0.
- Timeout: burst_len=7, 3 beats, then state forced to IDLE -> short_burst pulses once, 3 entries remain, resp_burst_cnt=0.
- Stray: rd_data_valid with state=WRITE_DATA1 -> stray=1 for one cycle, resp_cnt unchanged; a 5th beat with burst_len=3 -> stray=1, not pushed.
- Reset mid-burst: rst after 2 of 4 beats -> all outputs return to reset values next cycle; a fresh single-beat read then works normally.

Source files
------------

// File: rtl/mpmc11_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mpmc11_pkg
//  Description : Shared types for the mpmc11 controller slice: controller
//                states, command request, read-response beat record, and
//                beat-address helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mpmc11_pkg;

    localparam int MPMC11_AWID       = 32;
    localparam int MPMC11_DWID       = 256;
    localparam int MPMC11_TIDW       = 8;
    localparam int MPMC11_BEAT_BYTES = 32;

    typedef enum logic [3:0] {
        IDLE,
        PRECHARGE,
        ACTIVATE,
        READ_CMD,
        READ_DATA0,
        READ_DATA1,
        READ_DATA2,
        WRITE_CMD,
        WRITE_DATA0,
        WRITE_DATA1,
        WRITE_DATA2,
        REFRESH
    } mpmc11_state_t;

    typedef enum logic [4:0] {
        CMD_NOP,
        CMD_LOAD,
        CMD_STORE,
        CMD_ADD,
        CMD_AND,
        CMD_OR,
        CMD_EOR,
        CMD_MIN,
        CMD_MAX,
        CMD_SWAP,
        CMD_CAS
    } fta_cmd_t;

    typedef struct packed {
        fta_cmd_t                 cmd;
        logic [MPMC11_TIDW-1:0]   tid;
        logic [MPMC11_AWID-1:0]   adr;
        logic [MPMC11_DWID-1:0]   dat;
    } fta_cmd_request256_t;

    typedef struct packed {
        logic [MPMC11_TIDW-1:0]   tid;
        logic [MPMC11_AWID-1:0]   adr;
        logic [MPMC11_DWID-1:0]   dat;
        logic                     last;
    } mpmc11_rd_beat_t;

    // Address of beat 'idx' in a burst starting at a beat-aligned base.
    function automatic logic [MPMC11_AWID-1:0] mpmc11_beat_adr(
        input logic [MPMC11_AWID-1:0] base,
        input logic [5:0]             idx
    );
        return base + (MPMC11_AWID'(idx) << $clog2(MPMC11_BEAT_BYTES));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpmc11_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mpmc11_sync_fifo
//  Description : Single-clock FIFO with register-array storage. The head
//                entry is read straight out of the register array, so rdata
//                carries no combinational path from the write side.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                push, wdata   - write strobe/data (ignored when full unless
//                                a pop happens in the same cycle)
//                pop           - remove head (ignored when empty)
//                rdata         - head entry
//                full, empty   - status
//                count         - occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module mpmc11_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign count = r_wr_ptr - r_rd_ptr;
    assign empty = (count == '0);
    // Occupancy never exceeds DEPTH, so the MSB alone marks full.
    assign full  = count[c_AW];

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/mpmc11_rd_resp_collect_fta.sv
`default_nettype none
// ============================================================================
//  Module      : mpmc11_rd_resp_collect_fta
//  Description : Read-response collector behind the mpmc11 controller. Counts
//                DDR read beats (resp_burst_cnt), tags each beat with the
//                request tid and beat address, and queues beats for the
//                channel response path. Flags overflow, stray and short
//                bursts.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                state              - controller state
//                fifo_out           - command being serviced (tid, adr)
//                burst_len          - last beat index of the burst
//                rd_data_valid/rd_data - DDR read beat
//                resp_burst_cnt     - index of next expected beat
//                resp_v/resp_rdy/resp_beat - response queue head handshake
//                resp_cnt           - queue occupancy
//                ovf                - sticky beat-dropped flag
//                stray, short_burst - single-cycle error pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module mpmc11_rd_resp_collect_fta
    import mpmc11_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AWID  = 32,
    parameter int DWID  = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  mpmc11_state_t            state,
    input  fta_cmd_request256_t      fifo_out,
    input  logic [5:0]               burst_len,
    input  logic                     rd_data_valid,
    input  logic [DWID-1:0]          rd_data,
    output logic [5:0]               resp_burst_cnt,
    output logic                     resp_v,
    input  logic                     resp_rdy,
    output mpmc11_rd_beat_t          resp_beat,
    output logic [$clog2(DEPTH):0]   resp_cnt,
    output logic                     ovf,
    output logic                     stray,
    output logic                     short_burst
);

    localparam int c_BEAT_W = $bits(mpmc11_rd_beat_t);

    logic                    r_collect;   // previous cycle was in the read phase
    logic                    r_done;      // last beat already accepted this phase
    logic [5:0]              r_cnt;
    logic [5:0]              r_len;
    logic [MPMC11_TIDW-1:0]  r_tid;
    logic [AWID-1:0]         r_base;
    logic                    r_ovf;

    logic                    w_in_rd;
    logic                    w_capture;
    logic [AWID-1:0]         w_base;
    logic [5:0]              w_len;
    logic [MPMC11_TIDW-1:0]  w_tid;
    logic [5:0]              w_cnt;
    logic                    w_done;
    logic                    w_beat;
    logic                    w_last;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    mpmc11_rd_beat_t         w_push_beat;
    logic [c_BEAT_W-1:0]     w_head;
    logic                    w_unused_fields;

    // Command fields that this stage does not consume; ALU commands are
    // collected exactly like plain reads.
    assign w_unused_fields = ^{fifo_out.cmd, fifo_out.adr[4:0], fifo_out.dat};

    assign w_in_rd   = state inside {READ_DATA0, READ_DATA1, READ_DATA2};
    assign w_capture = (state == READ_DATA0) && !r_collect;

    // On the entry cycle the request is forwarded so a beat arriving in that
    // very cycle is still tagged with the new burst.
    assign w_base = w_capture ? {fifo_out.adr[AWID-1:5], 5'b0} : r_base;
    assign w_len  = w_capture ? burst_len    : r_len;
    assign w_tid  = w_capture ? fifo_out.tid : r_tid;
    assign w_cnt  = w_capture ? 6'd0         : r_cnt;
    assign w_done = w_capture ? 1'b0         : r_done;

    assign w_beat = rd_data_valid && w_in_rd && !w_done;
    assign w_last = (w_cnt == w_len);
    assign w_pop  = resp_v && resp_rdy;

    always_comb begin
        w_push_beat      = '0;
        w_push_beat.tid  = w_tid;
        w_push_beat.adr  = mpmc11_beat_adr(w_base, w_cnt);
        w_push_beat.dat  = rd_data;
        w_push_beat.last = w_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_collect <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_tid     <= '0;
            r_base    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_collect <= w_in_rd;
            if (w_capture) begin
                r_base <= w_base;
                r_len  <= w_len;
                r_tid  <= w_tid;
            end
            // Counter holds at burst_len after the last beat so the
            // controller sees cnt==burst_len alongside the final strobe.
            if (state == IDLE)
                r_cnt <= '0;
            else if (w_beat && !w_last)
                r_cnt <= w_cnt + 6'd1;
            else
                r_cnt <= w_cnt;
            r_done <= w_in_rd && (w_done || (w_beat && w_last));
            if (w_beat && w_full && !w_pop)
                r_ovf <= 1'b1;
        end
    end

    mpmc11_sync_fifo #(
        .WIDTH (c_BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_beat),
        .wdata (w_push_beat),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (resp_cnt)
    );

    assign resp_v         = !w_empty;
    assign resp_beat      = mpmc11_rd_beat_t'(w_head);
    assign resp_burst_cnt = r_cnt;
    assign ovf            = r_ovf;
    // Beats outside the phase, or beyond the last one, are discarded.
    assign stray          = !rst && rd_data_valid && (!w_in_rd || w_done);
    // Phase abandoned (timeout) before the last beat was accepted.
    assign short_burst    = !rst && (state == IDLE) && r_collect && !r_done;

endmodule
`default_nettype wire

// File: tb/tb_mpmc11_rd_resp_collect_fta.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mpmc11_rd_resp_collect_fta
//  Description : Self-checking bench for mpmc11_rd_resp_collect_fta. A queue
//                models the response buffer; expected beat tags come from
//                base/tid/len the bench itself issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mpmc11_rd_resp_collect_fta;
    import mpmc11_pkg::*;

    localparam int DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    mpmc11_state_t           state;
    fta_cmd_request256_t     fifo_out;
    logic [5:0]              burst_len;
    logic                    rd_data_valid;
    logic [255:0]            rd_data;
    logic [5:0]              resp_burst_cnt;
    logic                    resp_v;
    logic                    resp_rdy;
    mpmc11_rd_beat_t         resp_beat;
    logic [$clog2(DEPTH):0]  resp_cnt;
    logic                    ovf;
    logic                    stray;
    logic                    short_burst;

    always #5 clk = ~clk;

    mpmc11_rd_resp_collect_fta #(.DEPTH(DEPTH), .AWID(32), .DWID(256)) dut (
        .clk            (clk),
        .rst            (rst),
        .state          (state),
        .fifo_out       (fifo_out),
        .burst_len      (burst_len),
        .rd_data_valid  (rd_data_valid),
        .rd_data        (rd_data),
        .resp_burst_cnt (resp_burst_cnt),
        .resp_v         (resp_v),
        .resp_rdy       (resp_rdy),
        .resp_beat      (resp_beat),
        .resp_cnt       (resp_cnt),
        .ovf            (ovf),
        .stray          (stray),
        .short_burst    (short_burst)
    );

    int              errors = 0;
    int              checks = 0;
    mpmc11_rd_beat_t exp_q[$];
    bit              m_ovf;
    logic [7:0]      cur_tid;
    logic [31:0]     cur_base;
    int              cur_len;
    int              cur_k;

    // One clock: apply queue semantics (pop old head, then push if room).
    task automatic cyc(input bit push_en, input mpmc11_rd_beat_t b);
        bit pop;
        pop = resp_rdy && (exp_q.size() > 0);
        @(posedge clk); #1;
        if (pop) void'(exp_q.pop_front());
        if (push_en) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic go_idle();
        state = IDLE; rd_data_valid = 1'b0;
        cyc(1'b0, '0);
    endtask

    task automatic enter_read(input logic [7:0] tid, input logic [31:0] adr,
                              input int len, input fta_cmd_t cmd);
        resp_rdy = 1'b0; rd_data_valid = 1'b0;
        fifo_out.cmd = cmd; fifo_out.tid = tid; fifo_out.adr = adr;
        fifo_out.dat = {8{32'hA5A5_5A5A}};
        burst_len = 6'(len);
        state = READ_CMD;   cyc(1'b0, '0);
        state = READ_DATA0; cyc(1'b0, '0);
        // Scramble the request so only latched values can be right.
        fifo_out.tid = 8'($urandom); fifo_out.adr = $urandom;
        burst_len = 6'($urandom_range(0, 63));
        state = READ_DATA1; cyc(1'b0, '0);
        state = READ_DATA2;
        cur_tid = tid; cur_base = adr & 32'hFFFF_FFE0; cur_len = len; cur_k = 0;
    endtask

    // Drives one rd_data_valid strobe; returns stray as seen before the edge.
    task automatic send_beat(output logic s);
        mpmc11_rd_beat_t b;
        bit push;
        for (int i = 0; i < 8; i++) rd_data[i*32 +: 32] = $urandom;
        rd_data_valid = 1'b1;
        #1 s = stray;
        push   = (cur_k <= cur_len);
        b.tid  = cur_tid;
        b.adr  = cur_base + 32'(cur_k * 32);
        b.dat  = rd_data;
        b.last = (cur_k == cur_len);
        cyc(push, b);
        if (push) cur_k++;
        rd_data_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; state = IDLE; rd_data_valid = 1'b1; resp_rdy = 1'b0;
        fifo_out = '0; burst_len = '0; rd_data = '0;
        cyc(1'b0, '0); cyc(1'b0, '0);
        checks++; if (resp_burst_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", resp_burst_cnt); end
        checks++; if (resp_v !== 1'b0) begin errors++; $display("FAIL reset_resp_v: got %b exp 0", resp_v); end
        checks++; if (resp_cnt !== '0) begin errors++; $display("FAIL reset_resp_cnt: got %0d exp 0", resp_cnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", ovf); end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL reset_stray: got %b exp 0", stray); end
        checks++; if (short_burst !== 1'b0) begin errors++; $display("FAIL reset_short: got %b exp 0", short_burst); end
        rst = 1'b0; rd_data_valid = 1'b0;
        exp_q.delete(); m_ovf = 1'b0;
        cyc(1'b0, '0);
    endtask

    task automatic test_single_beat();
        logic s;
        enter_read(8'd5, 32'h1234_5678, 0, CMD_LOAD);
        checks++; if (resp_v !== 1'b0) begin errors++; $display("FAIL single_pre_v: got %b exp 0", resp_v); end
        send_beat(s);
        checks++; if (resp_v !== 1'b1) begin errors++; $display("FAIL single_v: got %b exp 1", resp_v); end
        checks++; if (resp_beat.tid !== 8'd5) begin errors++; $display("FAIL single_tid: got %0d exp 5", resp_beat.tid); end
        checks++; if (resp_beat.adr !== 32'h1234_5660) begin errors++; $display("FAIL single_adr: got %h exp 12345660", resp_beat.adr); end
        checks++; if (resp_beat.last !== 1'b1) begin errors++; $display("FAIL single_last: got %b exp 1", resp_beat.last); end
        checks++; if (resp_beat !== exp_q[0]) begin errors++; $display("FAIL single_beat: got %h exp %h", resp_beat, exp_q[0]); end
        cyc(1'b0, '0);
        checks++; if (resp_burst_cnt !== 6'd0) begin errors++; $display("FAIL single_cnt: got %0d exp 0", resp_burst_cnt); end
        go_idle();
        resp_rdy = 1'b1; cyc(1'b0, '0); resp_rdy = 1'b0;
        checks++; if (resp_v !== 1'b0) begin errors++; $display("FAIL single_drain: got %b exp 0", resp_v); end
    endtask

    task automatic test_burst4();
        logic s;
        enter_read(8'($urandom), 32'h0000_1000, 3, CMD_LOAD);
        for (int k = 0; k < 4; k++) begin
            checks++; if (resp_burst_cnt !== 6'(k)) begin errors++; $display("FAIL burst_cnt%0d: got %0d exp %0d", k, resp_burst_cnt, k); end
            send_beat(s);
        end
        checks++; if (resp_burst_cnt !== 6'd3) begin errors++; $display("FAIL burst_cnt_hold: got %0d exp 3", resp_burst_cnt); end
        checks++; if (resp_cnt !== 3'd4) begin errors++; $display("FAIL burst_resp_cnt: got %0d exp 4", resp_cnt); end
        go_idle();
        resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (resp_beat.adr !== 32'h1000 + 32'(32 * i)) begin errors++; $display("FAIL burst_adr%0d: got %h exp %h", i, resp_beat.adr, 32'h1000 + 32'(32 * i)); end
            checks++; if (resp_beat.last !== (i == 3)) begin errors++; $display("FAIL burst_last%0d: got %b", i, resp_beat.last); end
            checks++; if (resp_beat !== exp_q[0]) begin errors++; $display("FAIL burst_beat%0d: got %h exp %h", i, resp_beat, exp_q[0]); end
            cyc(1'b0, '0);
        end
        resp_rdy = 1'b0;
        checks++; if (resp_v !== 1'b0) begin errors++; $display("FAIL burst_empty: got %b exp 0", resp_v); end
    endtask

    task automatic test_overflow();
        logic s;
        enter_read(8'h21, 32'h0000_2000, 4, CMD_ADD);
        for (int k = 0; k < 4; k++) send_beat(s);
        // Full with a simultaneous pop: beat accepted, occupancy unchanged.
        resp_rdy = 1'b1;
        checks++; if (resp_beat !== exp_q[0]) begin errors++; $display("FAIL ovf_pop_head: got %h exp %h", resp_beat, exp_q[0]); end
        send_beat(s);
        resp_rdy = 1'b0;
        checks++; if (resp_cnt !== 3'd4) begin errors++; $display("FAIL ovf_pop_cnt: got %0d exp 4", resp_cnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_pop_flag: got %b exp 0", ovf); end
        go_idle();
        // Full without pop: beat dropped, ovf sticky.
        enter_read(8'h22, 32'h0000_3000, 0, CMD_LOAD);
        send_beat(s);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", ovf); end
        checks++; if (resp_cnt !== 3'd4) begin errors++; $display("FAIL ovf_drop_cnt: got %0d exp 4", resp_cnt); end
        go_idle(); cyc(1'b0, '0); cyc(1'b0, '0);
        checks++; if (ovf !== m_ovf || ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", ovf); end
        resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (resp_beat !== exp_q[0]) begin errors++; $display("FAIL ovf_drain%0d: got %h exp %h", i, resp_beat, exp_q[0]); end
            if (i == 3) begin
                checks++; if (resp_beat.adr !== 32'h2080 || resp_beat.last !== 1'b1) begin errors++; $display("FAIL ovf_tail: got adr %h last %b exp 2080/1", resp_beat.adr, resp_beat.last); end
            end
            cyc(1'b0, '0);
        end
        resp_rdy = 1'b0;
        checks++; if (resp_v !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b exp 0", resp_v); end
    endtask

    task automatic test_timeout();
        logic s;
        int pulses;
        enter_read(8'h33, 32'h0000_4000, 7, CMD_LOAD);
        for (int k = 0; k < 3; k++) send_beat(s);
        pulses = 0;
        state = IDLE;
        for (int i = 0; i < 4; i++) begin
            #1 if (short_burst === 1'b1) pulses++;
            cyc(1'b0, '0);
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d exp 1", pulses); end
        checks++; if (resp_cnt !== 3'd3) begin errors++; $display("FAIL timeout_cnt: got %0d exp 3", resp_cnt); end
        checks++; if (resp_burst_cnt !== 6'd0) begin errors++; $display("FAIL timeout_bcnt: got %0d exp 0", resp_burst_cnt); end
        resp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (resp_beat !== exp_q[0] || resp_beat.last !== 1'b0) begin errors++; $display("FAIL timeout_beat%0d: got %h exp %h", i, resp_beat, exp_q[0]); end
            cyc(1'b0, '0);
        end
        resp_rdy = 1'b0;
    endtask

    task automatic test_stray();
        logic s;
        int bad;
        state = WRITE_DATA1; rd_data_valid = 1'b1;
        #1 checks++; if (stray !== 1'b1) begin errors++; $display("FAIL stray_write: got %b exp 1", stray); end
        cyc(1'b0, '0);
        rd_data_valid = 1'b0;
        #1 checks++; if (stray !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b exp 0", stray); end
        checks++; if (resp_cnt !== '0) begin errors++; $display("FAIL stray_write_cnt: got %0d exp 0", resp_cnt); end
        go_idle();
        enter_read(8'h44, 32'h0000_5000, 3, CMD_CAS);
        bad = 0;
        for (int k = 0; k < 4; k++) begin send_beat(s); if (s !== 1'b0) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stray_inburst: got %0d stray pulses exp 0", bad); end
        send_beat(s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL stray_extra: got %b exp 1", s); end
        checks++; if (resp_burst_cnt !== 6'd3) begin errors++; $display("FAIL stray_bcnt: got %0d exp 3", resp_burst_cnt); end
        go_idle();
        resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (resp_beat !== exp_q[0]) begin errors++; $display("FAIL stray_drain%0d: got %h exp %h", i, resp_beat, exp_q[0]); end
            cyc(1'b0, '0);
        end
        resp_rdy = 1'b0;
        checks++; if (resp_v !== 1'b0) begin errors++; $display("FAIL stray_empty: got %b exp 0", resp_v); end
    endtask

    task automatic test_reset_mid_burst();
        logic s;
        enter_read(8'h55, 32'h0000_6000, 3, CMD_LOAD);
        send_beat(s); send_beat(s);
        rst = 1'b1; cyc(1'b0, '0);
        exp_q.delete(); m_ovf = 1'b0;
        checks++; if (resp_v !== 1'b0 || resp_cnt !== '0) begin errors++; $display("FAIL rstmid_fifo: got v=%b cnt=%0d exp 0/0", resp_v, resp_cnt); end
        checks++; if (resp_burst_cnt !== 6'd0 || ovf !== 1'b0) begin errors++; $display("FAIL rstmid_regs: got cnt=%0d ovf=%b exp 0/0", resp_burst_cnt, ovf); end
        checks++; if (stray !== 1'b0 || short_burst !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: got %b%b exp 00", stray, short_burst); end
        rst = 1'b0; go_idle();
        enter_read(8'h09, 32'hFFFF_FFFF, 0, CMD_LOAD);
        send_beat(s);
        checks++; if (resp_cnt !== 3'd1) begin errors++; $display("FAIL rstmid_fresh_cnt: got %0d exp 1", resp_cnt); end
        checks++; if (resp_beat.adr !== 32'hFFFF_FFE0 || resp_beat !== exp_q[0]) begin errors++; $display("FAIL rstmid_fresh_beat: got %h exp %h", resp_beat, exp_q[0]); end
        go_idle();
        resp_rdy = 1'b1; cyc(1'b0, '0); resp_rdy = 1'b0;
    endtask

    task automatic test_random_bursts();
        logic s;
        bit   exp_s;
        int   nb, sent, exp_bc;
        for (int n = 0; n < 16; n++) begin
            enter_read(8'($urandom), $urandom, $urandom_range(0, 5),
                       fta_cmd_t'($urandom_range(1, 10)));
            nb = $urandom_range(0, cur_len + 2);
            sent = 0;
            for (int guard = 0; guard < 60 && sent < nb; guard++) begin
                resp_rdy = 1'($urandom_range(0, 1));
                checks++; if (resp_v !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_v: got %b exp %b", resp_v, exp_q.size() != 0); end
                checks++; if (int'(resp_cnt) !== exp_q.size()) begin errors++; $display("FAIL rnd_cnt: got %0d exp %0d", resp_cnt, exp_q.size()); end
                if (resp_rdy && exp_q.size() > 0) begin
                    checks++; if (resp_beat !== exp_q[0]) begin errors++; $display("FAIL rnd_head: got %h exp %h", resp_beat, exp_q[0]); end
                end
                if ($urandom_range(0, 2) != 0) begin
                    exp_s = (cur_k > cur_len);
                    send_beat(s);
                    sent++;
                    checks++; if (s !== exp_s) begin errors++; $display("FAIL rnd_stray: got %b exp %b", s, exp_s); end
                end else begin
                    cyc(1'b0, '0);
                end
                exp_bc = (cur_k > cur_len) ? cur_len : cur_k;
                checks++; if (int'(resp_burst_cnt) !== exp_bc) begin errors++; $display("FAIL rnd_bcnt: got %0d exp %0d", resp_burst_cnt, exp_bc); end
                checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf: got %b exp %b", ovf, m_ovf); end
            end
            state = IDLE;
            resp_rdy = 1'($urandom_range(0, 1));
            #1 checks++; if (short_burst !== (cur_k <= cur_len)) begin errors++; $display("FAIL rnd_short: got %b exp %b", short_burst, cur_k <= cur_len); end
            cyc(1'b0, '0);
            checks++; if (resp_burst_cnt !== 6'd0) begin errors++; $display("FAIL rnd_idle_bcnt: got %0d exp 0", resp_burst_cnt); end
        end
        resp_rdy = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (exp_q.size() > 0) begin
                checks++; if (resp_beat !== exp_q[0]) begin errors++; $display("FAIL rnd_drain: got %h exp %h", resp_beat, exp_q[0]); end
            end
            cyc(1'b0, '0);
        end
        resp_rdy = 1'b0;
        checks++; if (resp_v !== 1'b0) begin errors++; $display("FAIL rnd_empty: got %b exp 0", resp_v); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_burst4();
        test_overflow();
        test_timeout();
        test_stray();
        test_reset_mid_burst();
        test_random_bursts();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
